// File: rtl/lcd_ctrl.sv
// lcd_ctrl: write-only HD44780 character-LCD controller.
//
// After reset it waits POWERUP_CYC cycles, then sends the fixed init
// sequence 0x38, 0x0C, 0x01, 0x06 (function set, display on, clear,
// entry mode). It then accepts user bytes one at a time. Each byte is
// strobed onto the bus as SETUP -> EN_HI -> HOLD -> WAIT. Clear/home
// commands get the long execution wait.
//
// Handshake: o_rdy is high only in IDLE. A request is taken on any rising
// edge where i_vld && o_rdy. i_vld while o_rdy is low is ignored, with no
// queueing.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_vld        request valid
//   i_rs         0 = command, 1 = data
//   i_data[7:0]  byte to write
//   o_rdy        ready to accept (IDLE)
//   o_init_done  power-on init sequence complete (sticky until reset)
//   o_lcd_on     LCD power enable
//   o_lcd_en     HD44780 enable strobe (registered)
//   o_lcd_rs     HD44780 register select
//   o_lcd_rw     HD44780 read/write, tied to write
//   o_lcd_data   HD44780 data bus
//
// All *_CYC parameters must be >= 1.
module lcd_ctrl #(
  parameter int POWERUP_CYC   = 750000,
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 25,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_vld,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_rdy,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  localparam logic [2:0] S_PWRUP   = 3'd0;
  localparam logic [2:0] S_INIT_LD = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_SETUP   = 3'd3;
  localparam logic [2:0] S_EN_HI   = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_WAIT    = 3'd6;

  localparam int MAX_A   = (POWERUP_CYC > SETUP_CYC) ? POWERUP_CYC : SETUP_CYC;
  localparam int MAX_B   = (EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC;
  localparam int MAX_C   = (WAIT_CYC > LONG_WAIT_CYC) ? WAIT_CYC : LONG_WAIT_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_cnt;
  logic          w_last;
  logic          w_timed;
  logic [1:0]    r_k;
  logic          r_init_done;
  logic          r_lcd_en;
  logic          r_lcd_rs;
  logic [7:0]    r_lcd_data;
  logic          r_lcd_on;
  logic          w_accept;
  logic          w_long;
  logic [7:0]    w_init_byte;

  assign w_accept = (r_state == S_IDLE) && i_vld;

  // Clear (0x01) and return-home (0x02/0x03) take far longer to execute.
  assign w_long = !r_lcd_rs &&
                  (r_lcd_data == 8'h01 || r_lcd_data == 8'h02 || r_lcd_data == 8'h03);

  always_comb begin
    w_init_byte = 8'h38;
    case (r_k)
      2'd0:    w_init_byte = 8'h38;
      2'd1:    w_init_byte = 8'h0C;
      2'd2:    w_init_byte = 8'h01;
      default: w_init_byte = 8'h06;
    endcase
  end

  // w_last marks the final cycle of a timed state. w_timed selects states
  // whose dwell is counted by r_cnt.
  always_comb begin
    w_next  = r_state;
    w_last  = 1'b0;
    w_timed = 1'b0;
    case (r_state)
      S_PWRUP: begin
        w_timed = 1'b1;
        w_last  = (r_cnt == CW'(POWERUP_CYC - 1));
        if (w_last) w_next = S_INIT_LD;
      end
      S_INIT_LD: w_next = S_SETUP;
      S_IDLE:    if (w_accept) w_next = S_SETUP;
      S_SETUP: begin
        w_timed = 1'b1;
        w_last  = (r_cnt == CW'(SETUP_CYC - 1));
        if (w_last) w_next = S_EN_HI;
      end
      S_EN_HI: begin
        w_timed = 1'b1;
        w_last  = (r_cnt == CW'(EN_CYC - 1));
        if (w_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        w_timed = 1'b1;
        w_last  = (r_cnt == CW'(HOLD_CYC - 1));
        if (w_last) w_next = S_WAIT;
      end
      S_WAIT: begin
        w_timed = 1'b1;
        w_last  = w_long ? (r_cnt == CW'(LONG_WAIT_CYC - 1))
                         : (r_cnt == CW'(WAIT_CYC - 1));
        if (w_last) begin
          if (!r_init_done && r_k != 2'd3) w_next = S_INIT_LD;
          else                             w_next = S_IDLE;
        end
      end
      default: w_next = S_PWRUP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_PWRUP;
      r_cnt       <= '0;
      r_k         <= 2'd0;
      r_init_done <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 8'h00;
      r_lcd_on    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_lcd_on <= 1'b1;
      r_cnt    <= (w_timed && !w_last) ? r_cnt + CW'(1) : '0;
      // Enable is decoded from the next state and registered, so the strobe is glitch-free.
      r_lcd_en <= (w_next == S_EN_HI);
      if (r_state == S_INIT_LD) begin
        r_lcd_rs   <= 1'b0;
        r_lcd_data <= w_init_byte;
      end else if (w_accept) begin
        r_lcd_rs   <= i_rs;
        r_lcd_data <= i_data;
      end
      if (r_state == S_WAIT && w_last && !r_init_done) begin
        if (r_k == 2'd3) r_init_done <= 1'b1;
        else             r_k         <= r_k + 2'd1;
      end
    end
  end

  assign o_rdy       = (r_state == S_IDLE);
  assign o_init_done = r_init_done;
  assign o_lcd_on    = r_lcd_on;
  assign o_lcd_en    = r_lcd_en;
  assign o_lcd_rs    = r_lcd_rs;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = r_lcd_data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Testbench for lcd_ctrl with small timing parameters.
// Each issued transfer pushes {rs,data} into exp_q. The monitor samples the
// bus on the falling clock edge. It checks each EN pulse (width, hold
// stability, bytes in order) against exp_q as the pulse ends. The main
// process checks reset values, handshake latencies and the init timing.
module tb_lcd_ctrl;

  localparam int P_PWRUP = 10;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 2;
  localparam int P_WAIT  = 5;
  localparam int P_LONG  = 20;
  localparam int BUSY_N  = P_SETUP + P_EN + P_HOLD + P_WAIT;   // 12
  localparam int BUSY_L  = P_SETUP + P_EN + P_HOLD + P_LONG;   // 27
  // Release to o_rdy: power-up, three normal init transfers, one long (0x01).
  localparam int INIT_N  = P_PWRUP + 3 * (1 + BUSY_N) + (1 + BUSY_L);  // 77

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_vld;
  logic       i_rs;
  logic [7:0] i_data;
  logic       o_rdy, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .POWERUP_CYC(P_PWRUP), .SETUP_CYC(P_SETUP), .EN_CYC(P_EN),
    .HOLD_CYC(P_HOLD), .WAIT_CYC(P_WAIT), .LONG_WAIT_CYC(P_LONG)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_vld(i_vld), .i_rs(i_rs), .i_data(i_data),
    .o_rdy(o_rdy), .o_init_done(o_init_done), .o_lcd_on(o_lcd_on),
    .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_data(o_lcd_data)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  int         gap_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_en = 1'b0;
  logic       have_prev_pulse = 1'b0;
  int         high_cnt = 0;
  int         low_cnt = 0;
  logic [8:0] rise_val;
  logic [8:0] exp_v;

  always @(negedge clk) begin
    if (!i_reset) begin
      prev_en  = 1'b0;
      high_cnt = 0;
      low_cnt  = 0;
    end else begin
      check("rw_low", {31'd0, o_lcd_rw}, 32'd0);
      if (o_lcd_en) begin
        if (!prev_en) begin
          if (have_prev_pulse) gap_q.push_back(low_cnt);
          rise_val = {o_lcd_rs, o_lcd_data};
          high_cnt = 0;
        end
        high_cnt++;
      end else begin
        if (prev_en) begin
          check("en_width", high_cnt, P_EN);
          check("hold_stable", {23'd0, o_lcd_rs, o_lcd_data}, {23'd0, rise_val});
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {23'd0, o_lcd_rs, o_lcd_data}, 32'h1ff);
          end else begin
            exp_v = exp_q.pop_front();
            check("pulse_byte", {23'd0, o_lcd_rs, o_lcd_data}, {23'd0, exp_v});
          end
          have_prev_pulse = 1'b1;
          low_cnt = 1;
        end else begin
          low_cnt++;
        end
      end
      prev_en = o_lcd_en;
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a falling edge. Counts rising edges until o_rdy is seen high.
  task automatic wait_rdy(output int cyc);
    logic done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (o_rdy) done = 1'b1;
    end
    if (!done) check("rdy_timeout", 32'd0, 32'd1);
  endtask

  // Release reset, run the init sequence, check its timing.
  task automatic run_init(input string tag);
    int cyc;
    gap_q.delete();
    have_prev_pulse = 1'b0;
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    i_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_lcd_on"}, {31'd0, o_lcd_on}, 32'd1);
    check({tag, "_rdy_early"}, {31'd0, o_rdy}, 32'd0);
    check({tag, "_done_early"}, {31'd0, o_init_done}, 32'd0);
    wait_rdy(cyc);
    check({tag, "_init_cycles"}, cyc + 1, INIT_N);
    check({tag, "_init_done"}, {31'd0, o_init_done}, 32'd1);
    check({tag, "_init_q_empty"}, exp_q.size(), 0);
    check({tag, "_gap_count"}, gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check({tag, "_gap_normal"}, gap_q[0], P_HOLD + P_WAIT + 1 + P_SETUP);
      check({tag, "_gap_after_clear"}, gap_q[2], P_HOLD + P_LONG + 1 + P_SETUP);
    end
  endtask

  // Call at a falling edge with o_rdy high. Sends one byte, then checks
  // the accept-edge bus value, EN start and busy span.
  task automatic send(input logic rs, input logic [7:0] data, input int busy);
    int cyc;
    int en_at;
    exp_q.push_back({rs, data});
    i_vld  = 1'b1;
    i_rs   = rs;
    i_data = data;
    @(posedge clk);
    #1;
    check("accept_rs", {31'd0, o_lcd_rs}, {31'd0, rs});
    check("accept_data", {24'd0, o_lcd_data}, {24'd0, data});
    i_vld  = 1'b0;
    i_data = ~data;
    cyc    = 0;
    en_at  = -1;
    forever begin
      @(negedge clk);
      if (o_lcd_en && en_at < 0) en_at = cyc;
      if (o_rdy || cyc >= 2000) break;
      @(posedge clk);
      cyc++;
    end
    check("en_start", en_at, P_SETUP);
    check("busy_span", cyc, busy);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int rdy_hits;
    logic [7:0] base;

    i_reset = 1'b0;
    i_vld   = 1'b0;
    i_rs    = 1'b0;
    i_data  = 8'h00;
    #3;
    check("rst_en", {31'd0, o_lcd_en}, 32'd0);
    check("rst_on", {31'd0, o_lcd_on}, 32'd0);
    check("rst_rdy", {31'd0, o_rdy}, 32'd0);
    check("rst_done", {31'd0, o_init_done}, 32'd0);
    check("rst_rs", {31'd0, o_lcd_rs}, 32'd0);
    check("rst_data", {24'd0, o_lcd_data}, 32'd0);
    repeat (2) @(negedge clk);

    run_init("init1");

    // Single transfers covering the long/short wait boundaries.
    send(1'b1, 8'h41, BUSY_N);
    send(1'b0, 8'h01, BUSY_L);
    send(1'b0, 8'h80, BUSY_N);
    send(1'b0, 8'h02, BUSY_L);
    send(1'b0, 8'h03, BUSY_L);
    send(1'b0, 8'h04, BUSY_N);
    send(1'b1, 8'h01, BUSY_N);
    send(1'b0, 8'h00, BUSY_N);

    // i_vld held with data changing every cycle: accepted at edges 0, 13, 26.
    base = 8'h60;
    exp_q.push_back({1'b1, base});
    exp_q.push_back({1'b1, base + 8'd13});
    exp_q.push_back({1'b1, base + 8'd26});
    rdy_hits = 0;
    i_vld = 1'b1;
    i_rs  = 1'b1;
    for (int j = 0; j <= 26; j++) begin
      i_data = base + 8'(j);
      @(posedge clk);
      @(negedge clk);
      if (j < 26) begin
        if (o_rdy) rdy_hits++;
        if (j == 12 || j == 25) check("burst_rdy_slot", {31'd0, o_rdy}, 32'd1);
      end
    end
    i_vld  = 1'b0;
    i_data = 8'hAA;
    check("burst_rdy_hits", rdy_hits, 2);
    wait_rdy(cyc);
    check("burst_last_span", cyc, BUSY_N);
    check("burst_q_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("idle_data_hold", {24'd0, o_lcd_data}, {24'd0, base + 8'd26});
    check("idle_rs_hold", {31'd0, o_lcd_rs}, 32'd1);

    // Reset during EN_HI: strobe drops with no clock edge, transfer discarded.
    exp_q.push_back({1'b1, 8'h55});
    i_vld  = 1'b1;
    i_rs   = 1'b1;
    i_data = 8'h55;
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("en_before_reset", {31'd0, o_lcd_en}, 32'd1);
    #2;
    i_reset = 1'b0;
    exp_q.delete();
    #1;
    check("async_en", {31'd0, o_lcd_en}, 32'd0);
    check("async_rdy", {31'd0, o_rdy}, 32'd0);
    check("async_data", {24'd0, o_lcd_data}, 32'd0);
    check("async_on", {31'd0, o_lcd_on}, 32'd0);
    check("async_done", {31'd0, o_init_done}, 32'd0);
    repeat (2) @(negedge clk);

    run_init("init2");
    send(1'b1, 8'h7E, BUSY_N);
    check("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
